// File: rtl/fu_share_arbiter_pkg.sv
// Shared definitions for the function-unit sharing arbiter: state encodings,
// statistics counter width and the single add function used by the datapath.
package fu_share_arbiter_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int unsigned STAT_W    = 16;
    // Widest operand the shared adder handles; callers zero-extend into it.
    localparam int unsigned ADD_MAX_W = 64;

    // The shared two-operand add; bit ADD_MAX_W is the carry-out.
    function automatic logic [ADD_MAX_W:0] fu_add(input logic [ADD_MAX_W-1:0] a,
                                                  input logic [ADD_MAX_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/fu_share_arbiter_rr_pick.sv
// Round-robin pick: first asserted request at or above ptr, wrapping at NREQ-1.
// Purely combinational.
module fu_share_arbiter_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    localparam int N = int'(NREQ);

    // Visit requesters in distance order from ptr; the first live one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int i = 0; i < N; i++) begin
                if (!any && req[i] && (((int'(ptr) + off) % N) == i)) begin
                    grant[i] = 1'b1;
                    idx      = IDW'(i);
                    any      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fu_share_arbiter.sv
// Shares one add function unit between NREQ requesters. One operation is
// accepted per cycle, the sum is registered and returned tagged with the
// winner's index. Drain and refill of the result register may coincide.
// Optional statistics counters: define FU_SHARE_ARBITER_STATS_EN.
module fu_share_arbiter
    import fu_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W:0]        rsp_data,
    input  logic              rsp_ready
`ifdef FU_SHARE_ARBITER_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] grant_cnt,
    output logic [STAT_W-1:0]      stall_cnt
`endif
);

    state_e             state_q;
    logic [IDW-1:0]     rr_ptr_q;
    logic [NREQ-1:0]    pick_grant;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic               can_accept;
    logic               accept;
    logic [IDW-1:0]     next_ptr;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic [ADD_MAX_W:0] sum_full;
    logic [W:0]         sum;
    logic               unused_sum_hi;

    fu_share_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Acceptance window, one-hot grant and round-robin successor.
    always_comb begin
        can_accept = (state_q == ST_EMPTY) | (rsp_valid & rsp_ready);
        accept     = can_accept & pick_any & ~rst;
        req_ready  = (can_accept && !rst) ? pick_grant : '0;
        next_ptr   = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
    end

    // Operand mux driven by the one-hot grant, then the shared adder.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (pick_grant[i]) begin
                op_a = op_a | req_a[i*W +: W];
                op_b = op_b | req_b[i*W +: W];
            end
        end
        sum_full      = fu_add(ADD_MAX_W'(op_a), ADD_MAX_W'(op_b));
        sum           = sum_full[W:0];
        unused_sum_hi = ^sum_full[ADD_MAX_W:W+1];
    end

    // Result-register FSM; accept takes priority over a plain drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rr_ptr_q  <= '0;
        end else if (accept) begin
            state_q   <= ST_FULL;
            rsp_valid <= 1'b1;
            rsp_id    <= pick_idx;
            rsp_data  <= sum;
            rr_ptr_q  <= next_ptr;
        end else if (rsp_valid && rsp_ready) begin
            state_q   <= ST_EMPTY;
            rsp_valid <= 1'b0;
        end
    end

`ifdef FU_SHARE_ARBITER_STATS_EN
    // Saturating per-requester grant counters and a shared stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int i = 0; i < int'(NREQ); i++) begin
                if (accept && pick_grant[i] && (grant_cnt[i*STAT_W +: STAT_W] != '1)) begin
                    grant_cnt[i*STAT_W +: STAT_W] <= grant_cnt[i*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
            if ((|req_valid) && !can_accept && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + STAT_W'(1);
            end
        end
    end
`else
    // Statistics disabled: no counter state.
`endif

endmodule

// File: tb/tb_fu_share_arbiter.sv
// Scoreboard bench for fu_share_arbiter: the driver computes the expected
// grant and result from the round-robin rules; a monitor compares whatever
// the DUT presents against the queued expectations.
module tb_fu_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [W:0]        rsp_data;
    logic              rsp_ready;
`ifdef FU_SHARE_ARBITER_STATS_EN
    logic [NREQ*16-1:0] grant_cnt;
    logic [15:0]        stall_cnt;
`endif

    fu_share_arbiter #(
        .NREQ (NREQ),
        .W    (W),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready)
`ifdef FU_SHARE_ARBITER_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int id;
        int data;
    } rsp_t;

    int              errors = 0;
    int              checks = 0;
    rsp_t            exp_q[$];
    rsp_t            stage;
    bit              stage_v = 1'b0;
    bit              mon_en = 1'b0;
    int              m_ptr = 0;
    bit              m_full = 1'b0;
    int              acc_cnt[NREQ];
    int              stall_m = 0;
    logic [NREQ-1:0] seen_ready;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus plus the reference model step.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ*W-1:0] a,
                         input logic [NREQ*W-1:0] b, input logic rdy);
        int g;
        bit can;
        @(negedge clk);
        if (stage_v) begin
            exp_q.push_back(stage);
            stage_v = 1'b0;
        end
        req_valid = v;
        req_a     = a;
        req_b     = b;
        rsp_ready = rdy;
        #1;
        can = !m_full || rdy;
        g = -1;
        if (can) begin
            for (int off = 0; off < NREQ; off++) begin
                int k;
                k = (m_ptr + off) % NREQ;
                if (v[k]) begin
                    g = k;
                    break;
                end
            end
        end
        seen_ready = req_ready;
        check("req_ready", req_ready, (g >= 0) ? (1 << g) : 0);
        if (g >= 0) begin
            stage.id   = g;
            stage.data = int'(a[g*W +: W]) + int'(b[g*W +: W]);
            stage_v    = 1'b1;
            m_ptr      = (g + 1) % NREQ;
            m_full     = 1'b1;
            acc_cnt[g]++;
        end else if (m_full && rdy) begin
            m_full = 1'b0;
        end
        if (v != 0 && !can) stall_m++;
    endtask

    // Async reset between edges while a result is held; model restarts too.
    task automatic mid_reset();
        @(posedge clk);
        #2;
        check("pre_reset_full", rsp_valid, 1);
        rst = 1'b1;
        #1;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_req_ready", req_ready, 0);
        exp_q.delete();
        stage_v = 1'b0;
        m_ptr   = 0;
        m_full  = 1'b0;
        stall_m = 0;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares the presented result with the head of the queue.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("rsp_valid", rsp_valid, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    if (rsp_valid) begin
                        check("rsp_id", rsp_id, exp_q[0].id);
                        check("rsp_data", rsp_data, exp_q[0].data);
                    end
                    if (rsp_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [NREQ*W-1:0] va;
        logic [NREQ*W-1:0] vb;
        logic [NREQ-1:0]   rv;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        #2;
        check("reset_valid", rsp_valid, 0);
        check("reset_id", rsp_id, 0);
        check("reset_data", rsp_data, 0);
        repeat (2) @(negedge clk);
        check("reset_ready_comb", req_ready, 0);
        req_valid = '0;
        rst       = 1'b0;
        mon_en    = 1'b1;

        // Single op on requester 0, then drain.
        va = '0; vb = '0;
        va[0 +: W] = 8'h0F;
        vb[0 +: W] = 8'h01;
        cycle(4'b0001, va, vb, 1'b1);
        cycle(4'b0000, '0, '0, 1'b1);
        check("single_valid", rsp_valid, 1);
        check("single_id", rsp_id, 0);
        check("single_data", rsp_data, 9'h010);
        cycle(4'b0000, '0, '0, 1'b1);
        check("single_drained", rsp_valid, 0);

        // Carry-out from requester 2.
        va = '0; vb = '0;
        va[2*W +: W] = 8'hFF;
        vb[2*W +: W] = 8'h02;
        cycle(4'b0100, va, vb, 1'b1);
        cycle(4'b0000, '0, '0, 1'b1);
        check("carry_id", rsp_id, 2);
        check("carry_data", rsp_data, 9'h101);

        // Restart round robin from 0 with a held result, then fairness.
        cycle(4'b0001, '0, '0, 1'b0);
        mid_reset();
        va = 32'h40302010;
        vb = 32'h04030201;
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, va, vb, 1'b1);
            check("rr_order", seen_ready, 4'b0001 << (i % NREQ));
        end

        // Backpressure then same-cycle drain and refill to requester 1.
        cycle(4'b0000, '0, '0, 1'b1);
        cycle(4'b0000, '0, '0, 1'b1);
        cycle(4'b1000, va, vb, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0110, va, vb, 1'b0);
            check("bp_ready", seen_ready, 4'b0000);
        end
        cycle(4'b0110, va, vb, 1'b1);
        check("bp_refill", seen_ready, 4'b0010);

        // Async reset while full, then first grant must go to requester 0.
        mid_reset();
        cycle(4'b1111, va, vb, 1'b1);
        check("post_reset_grant", seen_ready, 4'b0001);

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                va[i*W +: W] = W'($urandom);
                vb[i*W +: W] = W'($urandom);
            end
            rv = NREQ'($urandom);
            cycle(rv, va, vb, ($urandom_range(0, 3) != 0));
        end
        cycle(4'b0000, '0, '0, 1'b1);
        cycle(4'b0000, '0, '0, 1'b1);
        cycle(4'b0000, '0, '0, 1'b1);

`ifdef FU_SHARE_ARBITER_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            check("grant_cnt", grant_cnt[i*16 +: 16], acc_cnt[i]);
        end
        check("stall_cnt", stall_cnt, stall_m);
`endif

        @(negedge clk);
        #3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
